// File: rtl/par2serial_8b.sv
// par2serial_8b: TX-PHY parallel-to-serial stage.
// Shifts one WIDTH-bit symbol out per WIDTH clocks. Slots without data carry
// IDLE_SYM. After reset, SYNC_IDLES idle symbols are sent for link alignment
// before any data is accepted.
module par2serial_8b #(
   parameter int                 WIDTH      = 8,
   parameter logic [WIDTH-1:0]   IDLE_SYM   = 8'hBC,
   parameter int                 SYNC_IDLES = 4,
   parameter bit                 LSB_FIRST  = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             serial_out,
   output logic             bit_valid,
   output logic             sym_start,
   output logic             active
);

   localparam int CNT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int IDLE_W = $clog2(SYNC_IDLES + 1);

   localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(WIDTH - 1);
   localparam logic [IDLE_W-1:0] IDLE_DONE = IDLE_W'(SYNC_IDLES);

   typedef enum logic {SYNC, RUN} state_t;

   state_t             state_q;
   logic [CNT_W-1:0]   bit_cnt_q;
   logic [IDLE_W-1:0]  idle_cnt_q;
   logic [WIDTH-1:0]   shift_q;
   logic               serial_out_q;
   logic               bit_valid_q;
   logic               sym_start_q;
   logic               active_q;

   logic               load_slot;
   logic               take;
   logic [WIDTH-1:0]   sym_d;
   logic [IDLE_W-1:0]  idle_cnt_d;

   // Load-slot decode and selection of the symbol to load (data or idle).
   always_comb begin
      load_slot  = (bit_cnt_q == LAST_BIT);
      in_ready   = (state_q == RUN) && load_slot;
      take       = in_valid && in_ready;
      sym_d      = take ? in_data : IDLE_SYM;
      idle_cnt_d = idle_cnt_q + 1'b1;
   end

   // Sync/run sequencing, bit counter, shift register and registered outputs.
   // NOTE: every register here uses <= so all state updates see pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= SYNC;
         bit_cnt_q    <= LAST_BIT;
         idle_cnt_q   <= '0;
         // NOTE: the shift register is cleared too, so a symbol cut off by
         // reset can never leak out after release.
         shift_q      <= '0;
         serial_out_q <= 1'b0;
         bit_valid_q  <= 1'b0;
         sym_start_q  <= 1'b0;
         active_q     <= 1'b0;
      end else if (load_slot) begin
         bit_cnt_q   <= '0;
         sym_start_q <= 1'b1;
         bit_valid_q <= take;
         if (LSB_FIRST) begin
            serial_out_q <= sym_d[0];
            shift_q      <= sym_d >> 1;
         end else begin
            serial_out_q <= sym_d[WIDTH-1];
            shift_q      <= sym_d << 1;
         end
         if (state_q == SYNC) begin
            idle_cnt_q <= idle_cnt_d;
            if (idle_cnt_d == IDLE_DONE) begin
               state_q  <= RUN;
               active_q <= 1'b1;
            end
         end
      end else begin
         bit_cnt_q   <= bit_cnt_q + 1'b1;
         sym_start_q <= 1'b0;
         if (LSB_FIRST) begin
            serial_out_q <= shift_q[0];
            shift_q      <= shift_q >> 1;
         end else begin
            serial_out_q <= shift_q[WIDTH-1];
            shift_q      <= shift_q << 1;
         end
      end
   end

   assign serial_out = serial_out_q;
   assign bit_valid  = bit_valid_q;
   assign sym_start  = sym_start_q;
   assign active     = active_q;

endmodule

// File: tb/tb_par2serial_8b.sv
// Directed testbench for par2serial_8b: sync idles, single and back-to-back
// data symbols, ignored off-slot valids, mid-symbol reset and LSB-first order.
module tb_par2serial_8b;

   logic       clk;
   logic       reset;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic       serial_out;
   logic       bit_valid;
   logic       sym_start;
   logic       active;

   logic [7:0] in_data2;
   logic       in_valid2;
   logic       in_ready2;
   logic       serial_out2;
   logic       bit_valid2;
   logic       sym_start2;
   logic       active2;

   int checks   = 0;
   int failures = 0;

   par2serial_8b dut (
      .clk        (clk),
      .reset      (reset),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .serial_out (serial_out),
      .bit_valid  (bit_valid),
      .sym_start  (sym_start),
      .active     (active)
   );

   par2serial_8b #(.LSB_FIRST(1'b1)) dut_lsb (
      .clk        (clk),
      .reset      (reset),
      .in_data    (in_data2),
      .in_valid   (in_valid2),
      .in_ready   (in_ready2),
      .serial_out (serial_out2),
      .bit_valid  (bit_valid2),
      .sym_start  (sym_start2),
      .active     (active2)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock and sample 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Clock out one full symbol starting from a load slot and check every bit.
   // hold_v keeps in_valid asserted on the non-load cycles of this symbol.
   task automatic expect_sym(input logic [7:0] exp_sym, input logic exp_bv,
                             input logic exp_active, input logic hold_v,
                             input logic chk_lsb, input logic [7:0] exp_lsb,
                             input string tag);
      for (int b = 0; b < 8; b++) begin
         tick();
         if (b == 0) begin
            in_valid  = hold_v;
            in_valid2 = 1'b0;
            check({tag, " active"}, {7'd0, active}, {7'd0, exp_active});
         end
         if (b == 7) in_valid = 1'b0;
         check($sformatf("%s bit%0d", tag, b), {7'd0, serial_out}, {7'd0, exp_sym[7-b]});
         check($sformatf("%s bv%0d", tag, b), {7'd0, bit_valid}, {7'd0, exp_bv});
         check($sformatf("%s ss%0d", tag, b), {7'd0, sym_start}, {7'd0, logic'(b == 0)});
         if (b == 3) check({tag, " in_ready mid"}, {7'd0, in_ready}, 8'd0);
         if (chk_lsb) begin
            check($sformatf("%s lsb bit%0d", tag, b), {7'd0, serial_out2}, {7'd0, exp_lsb[b]});
            check($sformatf("%s lsb bv%0d", tag, b), {7'd0, bit_valid2}, 8'd1);
         end
      end
   endtask

   initial begin
      reset     = 1'b1;
      in_data   = 8'h00;
      in_valid  = 1'b0;
      in_data2  = 8'h00;
      in_valid2 = 1'b0;
      tick();
      tick();

      // Reset values
      check("rst serial_out", {7'd0, serial_out}, 8'd0);
      check("rst bit_valid",  {7'd0, bit_valid},  8'd0);
      check("rst sym_start",  {7'd0, sym_start},  8'd0);
      check("rst active",     {7'd0, active},     8'd0);
      check("rst in_ready",   {7'd0, in_ready},   8'd0);
      reset = 1'b0;

      // 1: four sync idles, MSB first, in_ready low in every sync load slot
      for (int k = 0; k < 4; k++) begin
         check($sformatf("sync%0d in_ready", k), {7'd0, in_ready}, 8'd0);
         expect_sym(8'hBC, 1'b0, logic'(k == 3), 1'b0, 1'b0, 8'h00, $sformatf("sync%0d", k));
      end

      // 2 + 6: A5 on the MSB-first unit, 01 on the LSB-first unit, then an idle
      check("a5 in_ready", {7'd0, in_ready}, 8'd1);
      in_data   = 8'hA5;
      in_valid  = 1'b1;
      in_data2  = 8'h01;
      in_valid2 = 1'b1;
      expect_sym(8'hA5, 1'b1, 1'b1, 1'b0, 1'b1, 8'h01, "a5");
      expect_sym(8'hBC, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, "idle_after_a5");

      // 3: back-to-back 00, FF, 3C with no idle between them
      in_data = 8'h00; in_valid = 1'b1;
      expect_sym(8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, "b2b_00");
      in_data = 8'hFF; in_valid = 1'b1;
      expect_sym(8'hFF, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, "b2b_ff");
      in_data = 8'h3C; in_valid = 1'b1;
      expect_sym(8'h3C, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, "b2b_3c");

      // 4: valid held only outside load slots is ignored
      in_data = 8'h55;
      expect_sym(8'hBC, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, "offslot0");
      expect_sym(8'hBC, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, "offslot1");

      // 5: reset during bit 3 of A5
      in_data = 8'hA5; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      tick();
      check("mid a5 bit3", {7'd0, serial_out}, 8'd0);
      check("mid a5 bv",   {7'd0, bit_valid},  8'd1);
      reset = 1'b1;
      #1;
      check("midrst serial_out", {7'd0, serial_out}, 8'd0);
      check("midrst bit_valid",  {7'd0, bit_valid},  8'd0);
      check("midrst sym_start",  {7'd0, sym_start},  8'd0);
      check("midrst active",     {7'd0, active},     8'd0);
      check("midrst in_ready",   {7'd0, in_ready},   8'd0);
      tick();
      reset = 1'b0;
      for (int k = 0; k < 4; k++) begin
         check($sformatf("resync%0d in_ready", k), {7'd0, in_ready}, 8'd0);
         expect_sym(8'hBC, 1'b0, logic'(k == 3), 1'b0, 1'b0, 8'h00, $sformatf("resync%0d", k));
      end
      check("post in_ready", {7'd0, in_ready}, 8'd1);
      in_data = 8'h3C; in_valid = 1'b1;
      expect_sym(8'h3C, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, "post_3c");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
